// File: rtl/btn_input_pkg.sv
// Shared types and constants for the push-button front end.
// Button indices, digit count and the edit/start/wait state encoding.
package btn_input_pkg;

  typedef enum logic [1:0] {
    EDIT  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam int BTN_C = 0;
  localparam int BTN_U = 1;
  localparam int BTN_D = 2;
  localparam int BTN_L = 3;
  localparam int BTN_R = 4;
  localparam int NUM_BTN = 5;
  localparam int NUM_DIGITS = 8;

endpackage

// File: rtl/btn_debounce.sv
// One push-button conditioner: 2-flop synchroniser, debounce counter,
// and a one-cycle press pulse on the debounced rising edge.
module btn_debounce #(
  parameter int DB_CYCLES = 4,
  parameter int DB_W      = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic press
);

  localparam logic [DB_W-1:0] LAST = DB_W'(DB_CYCLES - 1);

  logic            s1;
  logic            s2;
  logic            deb;
  logic            deb_d;
  logic [DB_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      deb   <= 1'b0;
      deb_d <= 1'b0;
      cnt   <= '0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      deb_d <= deb;
      if (s2 != deb) begin
        if (cnt == LAST) begin
          deb <= s2;
          cnt <= '0;
        end else begin
          cnt <= cnt + DB_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  // high only in the cycle right after deb rose
  assign press = deb & ~deb_d;

endmodule

// File: rtl/btn_input_ctrl.sv
// Push-button operand editor: five debounced buttons edit a hex
// operand, center launches a calculation and waits for cpu_done.
module btn_input_ctrl
  import btn_input_pkg::*;
#(
  parameter int DB_CYCLES = 4,
  parameter int DB_W      = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_center_in,
  input  logic        btn_up_in,
  input  logic        btn_down_in,
  input  logic        btn_left_in,
  input  logic        btn_right_in,
  input  logic        cpu_done,
  output logic [31:0] operand,
  output logic [2:0]  cursor,
  output logic        calc_start,
  output logic        busy,
  output logic        btn_up
);

  logic [NUM_BTN-1:0] raw;
  logic [NUM_BTN-1:0] press;
  logic [NUM_BTN-1:0] pick;
  logic [3:0]         dig;
  state_t             state;

  assign raw = {btn_right_in, btn_left_in, btn_down_in,
                btn_up_in, btn_center_in};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
    btn_debounce #(
      .DB_CYCLES(DB_CYCLES),
      .DB_W     (DB_W)
    ) u_db (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (raw[i]),
      .press(press[i])
    );
  end

  // lowest index wins, so center beats up beats down ...
  assign pick = press & (~press + NUM_BTN'(1));
  assign dig  = operand[{cursor, 2'b00} +: 4];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= EDIT;
      operand    <= '0;
      cursor     <= '0;
      calc_start <= 1'b0;
      busy       <= 1'b0;
      btn_up     <= 1'b0;
    end else begin
      btn_up     <= press[BTN_U];
      calc_start <= 1'b0;
      unique case (state)
        EDIT: begin
          busy <= 1'b0;
          unique case (1'b1)
            pick[BTN_C]: begin
              state      <= START;
              calc_start <= 1'b1;
              busy       <= 1'b1;
            end
            pick[BTN_U]: operand[{cursor, 2'b00} +: 4] <= dig + 4'd1;
            pick[BTN_D]: operand[{cursor, 2'b00} +: 4] <= dig - 4'd1;
            pick[BTN_L]: cursor <= cursor + 3'd1;
            pick[BTN_R]: cursor <= cursor - 3'd1;
            default: ;
          endcase
        end
        START: begin
          state <= WAIT;
          busy  <= 1'b1;
        end
        WAIT: begin
          if (cpu_done) begin
            state <= EDIT;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= EDIT;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btn_input_ctrl.sv
// Randomised bench for btn_input_ctrl with a cycle-level reference model
// plus directed checks of edit, priority, start latency and reset abort.
module tb_btn_input_ctrl;

  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  btn;
  logic        cpu_done;
  logic [31:0] operand;
  logic [2:0]  cursor;
  logic        calc_start;
  logic        busy;
  logic        btn_up;

  int n_chk = 0;
  int n_err = 0;
  int n_up  = 0;

  always #5 clk = ~clk;

  btn_input_ctrl #(.DB_CYCLES(DB), .DB_W(20)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_center_in(btn[0]),
    .btn_up_in    (btn[1]),
    .btn_down_in  (btn[2]),
    .btn_left_in  (btn[3]),
    .btn_right_in (btn[4]),
    .cpu_done     (cpu_done),
    .operand      (operand),
    .cursor       (cursor),
    .calc_start   (calc_start),
    .busy         (busy),
    .btn_up       (btn_up)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: delay line, mismatch run length, digit array
  logic m_p0[5];
  logic m_p1[5];
  logic m_deb[5];
  int   m_run[5];
  logic [4:0] m_pend;
  logic [4:0] m_new;
  int   m_dig[8];
  int   m_cur;
  int   m_mode;
  logic e_cs, e_busy, e_up;

  function automatic logic [31:0] m_op();
    logic [31:0] v;
    int d;
    v = '0;
    for (int i = 0; i < 8; i++) begin
      d = m_dig[i];
      v[i*4 +: 4] = d[3:0];
    end
    return v;
  endfunction

  always @(posedge clk) begin
    logic s;
    if (!rst_n) begin
      for (int b = 0; b < 5; b++) begin
        m_p0[b] = 1'b0; m_p1[b] = 1'b0; m_deb[b] = 1'b0; m_run[b] = 0;
      end
      for (int i = 0; i < 8; i++) m_dig[i] = 0;
      m_pend = '0; m_cur = 0; m_mode = 0;
      e_cs = 1'b0; e_busy = 1'b0; e_up = 1'b0;
    end else begin
      e_up = m_pend[1];
      e_cs = 1'b0;
      case (m_mode)
        0: begin
          e_busy = 1'b0;
          if (m_pend[0]) begin
            m_mode = 1; e_cs = 1'b1; e_busy = 1'b1;
          end else if (m_pend[1]) m_dig[m_cur] = (m_dig[m_cur] + 1) % 16;
          else if (m_pend[2]) m_dig[m_cur] = (m_dig[m_cur] + 15) % 16;
          else if (m_pend[3]) m_cur = (m_cur + 1) % 8;
          else if (m_pend[4]) m_cur = (m_cur + 7) % 8;
        end
        1: begin m_mode = 2; e_busy = 1'b1; end
        default: if (cpu_done) begin m_mode = 0; e_busy = 1'b0; end
      endcase
      for (int b = 0; b < 5; b++) begin
        s = m_p0[b];
        m_p0[b] = m_p1[b];
        m_p1[b] = btn[b];
        m_new[b] = 1'b0;
        if (s != m_deb[b]) begin
          m_run[b]++;
          if (m_run[b] == DB) begin
            m_deb[b] = s; m_run[b] = 0; m_new[b] = s;
          end
        end else m_run[b] = 0;
      end
      m_pend = m_new;
    end
  end

  always @(negedge clk) begin
    chk("operand", operand, m_op());
    chk("cursor", {29'd0, cursor}, m_cur);
    chk("calc_start", {31'd0, calc_start}, {31'd0, e_cs});
    chk("busy", {31'd0, busy}, {31'd0, e_busy});
    chk("btn_up", {31'd0, btn_up}, {31'd0, e_up});
    if (btn_up === 1'b1) n_up++;
  end

  task automatic press(input int idx, input int hi, input int lo);
    btn[idx] = 1'b1;
    repeat (hi) @(negedge clk);
    btn[idx] = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int lat;
    int up0;
    int hold;
    rst_n = 1'b0; btn = '0; cpu_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      btn = 5'($urandom);
    end
    @(negedge clk);
    btn = '0; rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("no_pulse_after_rst", n_up, 0);

    for (int i = 0; i < 5; i++) press(1, 10, 10);
    for (int i = 0; i < 3; i++) press(3, 10, 10);
    press(1, 10, 10);
    chk("op_1005", operand, 32'h0000_1005);
    chk("cursor_3", {29'd0, cursor}, 32'd3);
    chk("up_count_6", n_up, 6);

    do_reset();
    press(2, 10, 10);
    chk("down_wrap", operand, 32'h0000_000F);
    press(4, 10, 10);
    chk("right_wrap", {29'd0, cursor}, 32'd7);

    up0 = n_up;
    btn[1] = 1'b1;
    repeat (2) @(negedge clk);
    btn[1] = 1'b0;
    repeat (15) @(negedge clk);
    chk("glitch_op", operand, 32'h0000_000F);
    chk("glitch_pulse", n_up, up0);

    btn[1] = 1'b1; btn[3] = 1'b1;
    repeat (10) @(negedge clk);
    btn[1] = 1'b0; btn[3] = 1'b0;
    repeat (10) @(negedge clk);
    chk("prio_op", operand, 32'h1000_000F);
    chk("prio_cursor", {29'd0, cursor}, 32'd7);

    btn[0] = 1'b1;
    lat = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (calc_start === 1'b1) begin
        lat = i;
        break;
      end
    end
    chk("start_latency", lat, 7);
    btn[0] = 1'b0;
    @(negedge clk);
    chk("start_one_cycle", {31'd0, calc_start}, 32'd0);
    chk("busy_wait", {31'd0, busy}, 32'd1);
    repeat (10) @(negedge clk);
    press(1, 10, 10);
    chk("wait_hold_op", operand, 32'h1000_000F);
    cpu_done = 1'b1;
    @(negedge clk);
    cpu_done = 1'b0;
    chk("done_clears_busy", {31'd0, busy}, 32'd0);
    press(1, 10, 10);
    chk("edit_after_done", operand, 32'h2000_000F);

    press(0, 10, 10);
    chk("busy_again", {31'd0, busy}, 32'd1);
    do_reset();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_op", operand, 32'd0);
    repeat (5) @(negedge clk);
    cpu_done = 1'b1;
    @(negedge clk);
    cpu_done = 1'b0;
    @(negedge clk);
    chk("late_done_busy", {31'd0, busy}, 32'd0);
    chk("late_done_start", {31'd0, calc_start}, 32'd0);

    for (int n = 0; n < 600; n++) begin
      btn = 5'($urandom & $urandom);
      cpu_done = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 99) == 0) rst_n = 1'b0;
      hold = $urandom_range(1, 12);
      @(negedge clk);
      cpu_done = 1'b0;
      rst_n = 1'b1;
      repeat (hold - 1) @(negedge clk);
    end
    btn = '0;
    repeat (20) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
